// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decode handshake and redirect.
// The master view belongs to the fetch unit; the slave view belongs to its environment.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, misalign_err,
    input  imem_rvalid, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, misalign_err,
    output imem_rvalid, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC sequencing, credit-gated word fetches to a 1-cycle-latency memory,
// and a small response FIFO towards decode, with full flush on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                  clk,
  input logic                  reset,
  instr_fetch_unit_if.master   bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t           fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic             inflight;

  logic             has_entry;
  logic             pop;
  logic             push;
  logic             req;
  logic [CRD_W-1:0] credit;

  // Credit counts queued plus in-flight words, net of this cycle's pop.
  always_comb begin
    has_entry = !reset && (count != '0);
    pop       = has_entry && bus.dec_ready;
    credit    = CRD_W'(count) + CRD_W'(inflight) - CRD_W'(pop);
    req       = !reset && !bus.redirect_valid && (credit < CRD_W'(FIFO_DEPTH));
    push      = bus.imem_rvalid && inflight && !bus.redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= req;
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req) begin
          fetch_pc <= fetch_pc + 32'd4;
          req_pc   <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo[wr_ptr] <= '{instr: bus.imem_rdata, pc: req_pc};
  end

  assign bus.imem_req     = req;
  assign bus.imem_addr    = fetch_pc;
  assign bus.dec_valid    = has_entry;
  assign bus.dec_instr    = fifo[rd_ptr].instr;
  assign bus.dec_pc       = fifo[rd_ptr].pc;
  assign bus.misalign_err = !reset && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  // The credit scheme must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

endmodule
